// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: widths, I/O select bit
// default and the FSM state encodings.
package mem_stage_ctrl_pkg;

    localparam int LEN_WORD        = 32;
    localparam int LEN_MEM_ADDR    = 20;
    localparam int IO_ADDR_BIT_DEF = 31;
    localparam int LEN_OFFSET      = 16;
    localparam int LEN_RD          = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;

    // Sign-extend a 16-bit displacement to a full data word.
    function automatic logic [LEN_WORD-1:0] sext_offset(input logic [LEN_OFFSET-1:0] off);
        return {{(LEN_WORD-LEN_OFFSET){off[LEN_OFFSET-1]}}, off};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_addr_gen.sv
// mem_addr_gen: combinational effective-address generator. Produces the byte
// effective address, the word address presented to memory, the I/O select
// flag and a misalignment flag (low two address bits non-zero).
module mem_addr_gen
    import mem_stage_ctrl_pkg::*;
#(
    parameter int LEN_WORD     = mem_stage_ctrl_pkg::LEN_WORD,
    parameter int LEN_MEM_ADDR = mem_stage_ctrl_pkg::LEN_MEM_ADDR,
    parameter int IO_ADDR_BIT  = mem_stage_ctrl_pkg::IO_ADDR_BIT_DEF
) (
    input  logic [LEN_WORD-1:0]     base,
    input  logic [LEN_OFFSET-1:0]   offset,
    output logic [LEN_WORD-1:0]     ea,
    output logic [LEN_MEM_ADDR-1:0] word_addr,
    output logic                    io,
    output logic                    misaligned
);

    // Wrap past the top of the address space is intentionally silent.
    always_comb begin
        ea         = base + sext_offset(offset);
        word_addr  = ea[LEN_MEM_ADDR+1:2];
        io         = ea[IO_ADDR_BIT];
        misaligned = |ea[1:0];
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access stage between execute and the memory block.
// Takes one op per handshake, issues a single request to memory, waits for
// accepted/accessed and hands the result to write-back.
// Optional: define MEM_STAGE_MISALIGN_TRAP_EN to turn misaligned load/store
// into an exception result (no memory request, out_exc=1, out_data=ea).
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int LEN_WORD     = mem_stage_ctrl_pkg::LEN_WORD,
    parameter int LEN_MEM_ADDR = mem_stage_ctrl_pkg::LEN_MEM_ADDR,
    parameter int IO_ADDR_BIT  = mem_stage_ctrl_pkg::IO_ADDR_BIT_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_is_load,
    input  logic                    in_is_store,
    input  logic [LEN_WORD-1:0]     in_base,
    input  logic [LEN_OFFSET-1:0]   in_offset,
    input  logic [LEN_WORD-1:0]     in_data,
    input  logic [LEN_RD-1:0]       in_rd,
    output logic                    mem_order,
    output logic                    mem_we,
    output logic                    mem_io,
    output logic [LEN_MEM_ADDR-1:0] mem_address,
    output logic [LEN_WORD-1:0]     mem_wdata,
    input  logic                    mem_accepted,
    input  logic                    mem_accessed,
    input  logic [LEN_WORD-1:0]     mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_we,
    output logic [LEN_RD-1:0]       out_rd,
    output logic [LEN_WORD-1:0]     out_data,
    output logic                    out_exc
);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state_q, state_d;

    logic [LEN_WORD-1:0]     ea;
    logic [LEN_MEM_ADDR-1:0] word_addr;
    logic                    io;
    logic                    misaligned;

    logic                    is_mem;
    logic                    trap;
    logic                    capture;
    logic                    done;
    logic                    idle_c;

    logic                    is_store_q;
    logic                    io_q;
    logic [LEN_MEM_ADDR-1:0] addr_q;
    logic [LEN_WORD-1:0]     wdata_q;
    logic [LEN_RD-1:0]       rd_q;
    logic                    out_we_q;
    logic [LEN_WORD-1:0]     out_data_q;
    logic                    exc_q;

    mem_addr_gen #(
        .LEN_WORD     (LEN_WORD),
        .LEN_MEM_ADDR (LEN_MEM_ADDR),
        .IO_ADDR_BIT  (IO_ADDR_BIT)
    ) u_addr_gen (
        .base       (in_base),
        .offset     (in_offset),
        .ea         (ea),
        .word_addr  (word_addr),
        .io         (io),
        .misaligned (misaligned)
    );

    assign is_mem  = in_is_load | in_is_store;
    assign trap    = TRAP_EN & is_mem & misaligned;
    assign capture = (state_q == S_IDLE) & in_valid;
    // Memory completes either in the accepting REQ cycle or later from WAIT.
    assign done    = ((state_q == S_REQ)  & mem_accepted & mem_accessed) |
                     ((state_q == S_WAIT) & mem_accessed);

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        idle_c    = 1'b0;
        mem_order = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_c = 1'b1;
                if (in_valid) begin
                    if (trap || !is_mem) state_d = S_RESP;
                    else                 state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_order = 1'b1;
                if (mem_accepted) state_d = mem_accessed ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_accessed) state_d = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields: captured once per op and held for the whole request.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            is_store_q <= 1'b0;
            io_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else if (capture) begin
            is_store_q <= in_is_store;
            io_q       <= io;
            addr_q     <= word_addr;
            wdata_q    <= in_data;
            rd_q       <= in_rd;
        end
    end

    // Result fields: set at capture for pass-through/trap, at completion for
    // memory ops; untouched while RESP waits on out_ready.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_we_q   <= 1'b0;
            out_data_q <= '0;
            exc_q      <= 1'b0;
        end else if (capture) begin
            exc_q <= trap;
            if (trap) begin
                out_we_q   <= 1'b0;
                out_data_q <= ea;
            end else if (!is_mem) begin
                out_we_q   <= (in_rd != '0);
                out_data_q <= in_data;
            end else begin
                out_we_q   <= 1'b0;
                out_data_q <= '0;
            end
        end else if (done) begin
            if (is_store_q) begin
                out_we_q   <= 1'b0;
                out_data_q <= '0;
            end else begin
                out_we_q   <= (rd_q != '0);
                out_data_q <= mem_rdata;
            end
        end
    end

    // in_ready is forced low while reset is held even though state is IDLE.
    assign in_ready    = idle_c & ~rstn;
    assign mem_we      = mem_order & is_store_q;
    assign mem_io      = io_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign out_we      = out_we_q;
    assign out_rd      = rd_q;
    assign out_data    = out_data_q;
    assign out_exc     = TRAP_EN ? exc_q : 1'b0;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Pipeline memory-access controller between the execute stage and the `memory` block.
- Takes one load/store/pass-through op per handshake and computes the effective address.
- Drives `memory`'s order/io/address/data request and waits for accepted, then accessed.
- Hands the result (load data or ALU result) to write-back over a valid/ready handshake.

Parameters:
- LEN_WORD, 32, data word width.
- LEN_MEM_ADDR, 20, word-address width presented to `memory`.
- IO_ADDR_BIT, 31, byte-address bit selecting the I/O space (1 = I/O).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-high: asserted = reset. Port named per codebase convention.
- in_valid  in  1  execute stage presents op.
- in_ready  out  1  controller can take op.
- in_is_load  in  1  op is load.
- in_is_store  in  1  op is store. Load and store are never both 1.
- in_base  in  LEN_WORD  base register value / ALU result.
- in_offset  in  16  signed displacement.
- in_data  in  LEN_WORD  store data, or pass-through result.
- in_rd  in  5  destination register.
- mem_order  out  1  request to `memory`.
- mem_we  out  1  request is a write.
- mem_io  out  1  request targets I/O.
- mem_address  out  LEN_MEM_ADDR  word address.
- mem_wdata  out  LEN_WORD  write data (feeds `memory` i_data).
- mem_accepted  in  1  `memory` took request.
- mem_accessed  in  1  `memory` completed; mem_rdata valid.
- mem_rdata  in  LEN_WORD  read data (`memory` o_data).
- out_valid  out  1  result to write-back.
- out_ready  in  1  write-back takes result.
- out_we  out  1  register write enable.
- out_rd  out  5  destination register.
- out_data  out  LEN_WORD  result.
- out_exc  out  1  misaligned-access exception.

Behaviour:
- Reset (async, rstn=1):
  - State goes to IDLE.
  - All outputs are 0 except in_ready, which is 0 while reset is held and 1 in the first IDLE cycle after release.
- Effective address:
  - ea = in_base + sign-extended in_offset, mod 2^32, computed on capture.
  - mem_address = ea[LEN_MEM_ADDR+1:2].
  - mem_io = ea[IO_ADDR_BIT].
  - Address and I/O fields are registered and stable for the whole request.
- FSM with states IDLE, REQ, WAIT, RESP.
  - IDLE:
    - in_ready=1.
    - On in_valid, capture all inputs.
    - Load or store: go to REQ.
    - Otherwise (pass-through): go to RESP with out_data=in_data and out_we=(in_rd!=0).
  - REQ:
    - mem_order=1; mem_we=is_store; mem_wdata=store data.
    - mem_accepted=0: stay in REQ, request held unchanged.
    - mem_accepted=1 and mem_accessed=0: go to WAIT.
    - mem_accepted=1 and mem_accessed=1 in the same cycle: go straight to RESP.
  - WAIT:
    - mem_order=0.
    - On mem_accessed, go to RESP.
    - Load: latch mem_rdata into out_data, out_we=(rd!=0).
    - Store: out_we=0, out_data=0.
  - RESP:
    - out_valid=1; outputs held stable until out_ready.
    - On out_valid and out_ready, go to IDLE.
- Latency:
  - Pass-through: out_valid 1 cycle after capture.
  - Load/store: 2 cycles after capture at best (accepted and accessed together in the first REQ cycle).
  - Throughput: at most one op in flight; in_ready is low outside IDLE.
- Boundary conditions:
  - mem_accessed outside REQ/WAIT is ignored.
  - rd=0 load: access still performed, out_we=0.
  - ea wrap past 0xFFFFFFFF is silent.
  - Reset mid-transaction: request abandoned, mem_order drops asynchronously. `memory` is reset by the same event.
- out_exc: 0 unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: a load/store with ea[1:0]!=0 issues no request. FSM goes IDLE→RESP with out_exc=1, out_we=0, out_data=ea.
- Undefined: ea[1:0] ignored; out_exc is tied 0.

Decomposition:
- Shared include holds:
  - LEN_WORD, LEN_MEM_ADDR.
  - FSM state encodings (2-bit localparams).
  - IO_ADDR_BIT default.
- One sub-module, mem_addr_gen, is natural. It is combinational and takes base and offset. Outputs:
  - ea
  - word address
  - io flag
  - misaligned flag

Test Plan:
1. Pass-through, in_data=0x1234, rd=5, out_ready=1 → out_valid one cycle after capture, out_we=1, out_data=0x1234; back in IDLE next cycle.
2. Load, base=0x100, offset=-4 → mem_address=0x3F, mem_io=0, mem_we=0.
   - Memory: accepted after 2 cycles, accessed 3 cycles later with rdata=0xDEADBEEF.
   - Expect out_data=0xDEADBEEF, out_we=1; mem_order held steady until accepted.
3. Store to base=0x80000010 → mem_io=1, mem_we=1, mem_wdata=in_data; with accepted+accessed in the same cycle → RESP directly, out_we=0.
4. out_ready held low 4 cycles in RESP → out_* stable, in_ready=0; completes on the first out_ready=1.
5. rstn asserted while in WAIT → mem_order=0, out_valid=0 immediately; after release in_ready=1 and a new op completes normally.
6. With MEM_STAGE_MISALIGN_TRAP_EN defined, load ea=0x102 → no mem_order, out_exc=1, out_data=0x102. Undefined → request issued at address 0x40.
